// File: rtl/fsm_stream_arbiter.sv
// rtl/fsm_stream_arbiter.sv - round-robin arbiter sharing one serial engine among requesters
// Streams the winner's burst into the engine and returns the aligned, tagged response bits.
module fsm_stream_arbiter #(
  parameter int N_REQ = 4,
  parameter int LEN_W = 4,
  parameter int LAT   = 2
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [N_REQ-1:0]       Req,
  input  logic [N_REQ*LEN_W-1:0] BurstLen,
  input  logic [N_REQ-1:0]       ReqBit,
  output logic [N_REQ-1:0]       Grant,
  output logic                   BitStrobe,
  output logic                   EngIn,
  output logic                   EngRst,
  input  logic                   EngOut,
  output logic                   RespBit,
  output logic                   RespValid,
  output logic                   Done,
  output logic                   Busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DRN_W = $clog2(LAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   cand;
  logic               win_found;
  logic [LEN_W-1:0]   win_len;
  logic [LEN_W-1:0]   len;
  logic [LEN_W:0]     bit_cnt;
  logic [DRN_W-1:0]   drain_cnt;
  logic [LAT:0]       strobe_dly;
  logic               stream_last;
  logic               drain_last;

  // Round-robin search: first requester at or above the pointer, wrapping modulo N_REQ.
  always_comb begin
    win       = '0;
    cand      = '0;
    win_found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = PTR_W'((int'(ptr) + i) % N_REQ);
      if (!win_found && Req[cand]) begin
        win       = cand;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    win_len = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == PTR_W'(i)) win_len = BurstLen[i*LEN_W +: LEN_W];
    end
  end

  assign stream_last = (bit_cnt == {1'b0, len});
  // Drain spans the EngIn register stage plus the engine latency minus the first stream edge,
  // so the final response lands in the DONE cycle.
  assign drain_last  = (drain_cnt == DRN_W'(LAT - 1));

  always_comb begin
    state_nxt = state;
    BitStrobe = 1'b0;
    Done      = 1'b0;
    Busy      = 1'b1;
    EngRst    = Reset;
    case (state)
      S_IDLE: begin
        Busy = 1'b0;
        if (win_found) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        EngRst    = 1'b1;
        state_nxt = S_STREAM;
      end
      S_STREAM: begin
        BitStrobe = 1'b1;
        if (stream_last) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        Done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      ptr        <= '0;
      owner      <= '0;
      len        <= '0;
      Grant      <= '0;
      EngIn      <= 1'b0;
      bit_cnt    <= '0;
      drain_cnt  <= '0;
      strobe_dly <= '0;
    end else begin
      state      <= state_nxt;
      strobe_dly <= {strobe_dly[LAT-1:0], BitStrobe};
      case (state)
        S_IDLE: begin
          if (win_found) begin
            owner     <= win;
            len       <= win_len;
            Grant     <= N_REQ'(1) << win;
            bit_cnt   <= '0;
            drain_cnt <= '0;
            EngIn     <= 1'b0;
          end
        end
        S_STREAM: begin
          EngIn   <= ReqBit[owner];
          bit_cnt <= bit_cnt + 1'b1;
        end
        S_DRAIN: drain_cnt <= drain_cnt + 1'b1;
        S_DONE: begin
          ptr   <= (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
          Grant <= '0;
        end
        default: ;
      endcase
    end
  end

  assign RespValid = strobe_dly[LAT];
  assign RespBit   = RespValid & EngOut;

endmodule

// File: tb/tb_fsm_stream_arbiter.sv
// tb/tb_fsm_stream_arbiter.sv - scoreboard bench for fsm_stream_arbiter
// Main instance at LAT=2 plus LAT=1 / LAT=3 instances for the latency sweep.
`timescale 1ns/1ps
module tb_fsm_stream_arbiter;

  localparam int N   = 4;
  localparam int LW  = 4;
  localparam int LAT = 2;

  logic            Clock = 1'b0;
  logic            Reset;
  logic [N-1:0]    Req;
  logic [N*LW-1:0] BurstLen;
  logic [N-1:0]    ReqBit;
  logic [N-1:0]    Grant;
  logic            BitStrobe, EngIn, EngRst, EngOut, RespBit, RespValid, Done, Busy;

  logic [N-1:0]    req_s;
  logic [N*LW-1:0] blen_s;
  logic [N-1:0]    rbit1, rbit3, g1, g3;
  logic            st1, ei1, er1, eo1, rb1, rv1, d1, b1;
  logic            st3, ei3, er3, eo3, rb3, rv3, d3, b3;

  typedef struct {logic [N-1:0] g; logic b;} exp_t;
  exp_t            q[$];
  exp_t            e;

  logic [15:0]     pat [N];
  logic [4:0]      sidx [N];
  logic [LAT-1:0]  eng;
  logic            eng1;
  logic [2:0]      eng3;
  logic [1:0]      sidx1, sidx3;
  int              n_vec = 0;
  int              n_err = 0;
  int              cycle = 0;
  int              prev_done = 0;

  always #5 Clock = ~Clock;

  fsm_stream_arbiter #(.N_REQ(N), .LEN_W(LW), .LAT(LAT)) dut (
    .Clock(Clock), .Reset(Reset), .Req(Req), .BurstLen(BurstLen), .ReqBit(ReqBit),
    .Grant(Grant), .BitStrobe(BitStrobe), .EngIn(EngIn), .EngRst(EngRst), .EngOut(EngOut),
    .RespBit(RespBit), .RespValid(RespValid), .Done(Done), .Busy(Busy));

  fsm_stream_arbiter #(.N_REQ(N), .LEN_W(LW), .LAT(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .Req(req_s), .BurstLen(blen_s), .ReqBit(rbit1),
    .Grant(g1), .BitStrobe(st1), .EngIn(ei1), .EngRst(er1), .EngOut(eo1),
    .RespBit(rb1), .RespValid(rv1), .Done(d1), .Busy(b1));

  fsm_stream_arbiter #(.N_REQ(N), .LEN_W(LW), .LAT(3)) dut3 (
    .Clock(Clock), .Reset(Reset), .Req(req_s), .BurstLen(blen_s), .ReqBit(rbit3),
    .Grant(g3), .BitStrobe(st3), .EngIn(ei3), .EngRst(er3), .EngOut(eo3),
    .RespBit(rb3), .RespValid(rv3), .Done(d3), .Busy(b3));

  // Engine models: EngOut follows EngIn after LAT edges.
  always @(posedge Clock) begin
    cycle <= cycle + 1;
    eng   <= EngRst ? '0 : {eng[LAT-2:0], EngIn};
    eng1  <= er1 ? 1'b0 : ei1;
    eng3  <= er3 ? 3'b0 : {eng3[1:0], ei3};
  end
  assign EngOut = eng[LAT-1];
  assign eo1    = eng1;
  assign eo3    = eng3[2];

  // Requester bit sources: each advances on its own consumed strobes.
  always @(posedge Clock) begin
    for (int i = 0; i < N; i++) begin
      if (EngRst) sidx[i] <= '0;
      else if (BitStrobe && Grant[i]) sidx[i] <= sidx[i] + 1'b1;
    end
    sidx1 <= er1 ? 2'd0 : (st1 ? sidx1 + 1'b1 : sidx1);
    sidx3 <= er3 ? 2'd0 : (st3 ? sidx3 + 1'b1 : sidx3);
  end
  always_comb begin
    for (int i = 0; i < N; i++) ReqBit[i] = pat[i][sidx[i][3:0]];
  end
  assign rbit1 = {3'b000, sidx1 == 2'd1};
  assign rbit3 = {3'b000, sidx3 == 2'd1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_len(input int i, input logic [LW-1:0] v);
    BurstLen[i*LW +: LW] = v;
  endtask

  task automatic push_bits(input logic [N-1:0] g, input logic [15:0] p, input int n);
    for (int k = 0; k < n; k++) q.push_back('{g, p[k]});
  endtask

  // Response monitor: every RespValid pops one expected (grant, bit) pair.
  always @(negedge Clock) begin
    if (!Reset) begin
      if (RespValid) begin
        if (q.size() == 0) chk("resp_unexpected", 32'(RespValid), 32'd0);
        else begin
          e = q.pop_front();
          chk("resp_bit", 32'(RespBit), 32'(e.b));
          chk("resp_grant", 32'(Grant), 32'(e.g));
        end
      end else begin
        chk("resp_gate", 32'(RespBit), 32'd0);
      end
    end
  end

  // Cycle-level check of one burst from CLEAR (c=0) through the following IDLE cycle.
  task automatic run_burst(input logic [N-1:0] g, input int len, input int drop_c,
                           input logic [N-1:0] req_after, input bit gap_chk);
    int t, nrv, last;
    last = len + LAT + 1;
    t = 0;
    while (!Busy && t < 40) begin
      @(negedge Clock);
      t++;
    end
    chk("start_timeout", 32'(Busy), 32'd1);
    if (!Busy) return;
    nrv = 0;
    for (int c = 0; c <= last + 1; c++) begin
      chk("grant", 32'(Grant), (c <= last) ? 32'(g) : 32'd0);
      chk("eng_rst", 32'(EngRst), 32'(c == 0));
      chk("bit_strobe", 32'(BitStrobe), 32'(c >= 1 && c <= len));
      chk("done", 32'(Done), 32'(c == last));
      chk("busy", 32'(Busy), 32'(c <= last));
      if (RespValid) nrv++;
      if (c == last) begin
        if (gap_chk) chk("done_gap", 32'(cycle - prev_done), 32'd6);
        prev_done = cycle;
      end
      if (c == drop_c) Req = req_after;
      if (c <= last) @(negedge Clock);
    end
    chk("resp_count", 32'(nrv), 32'(len));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    Reset = 1'b1; Req = '0; BurstLen = '0; req_s = '0; blen_s = '0;
    for (int i = 0; i < N; i++) pat[i] = '0;
    repeat (2) @(negedge Clock);
    chk("rst_grant", 32'(Grant), 32'd0);
    chk("rst_engrst", 32'(EngRst), 32'd1);
    chk("rst_engin", 32'(EngIn), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_strobe", 32'(BitStrobe), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_respvalid", 32'(RespValid), 32'd0);
    Reset = 1'b0;
    repeat (3) begin
      @(negedge Clock);
      chk("idle_busy", 32'(Busy), 32'd0);
      chk("idle_grant", 32'(Grant), 32'd0);
      chk("idle_strobe", 32'(BitStrobe), 32'd0);
      chk("idle_engrst", 32'(EngRst), 32'd0);
    end

    // Single 4-bit burst, stream 1,0,1,1.
    set_len(0, 4'd3); pat[0] = 16'b1101;
    push_bits(4'b0001, 16'b1101, 4);
    Req = 4'b0001;
    run_burst(4'b0001, 4, 1, 4'b0000, 1'b0);

    // All requesting with 1-bit bursts: full round-robin rotation from pointer 0.
    Reset = 1'b1; @(negedge Clock); Reset = 1'b0;
    BurstLen = '0;
    pat[0] = 16'h0001; pat[1] = 16'h0000; pat[2] = 16'h0001; pat[3] = 16'h0000;
    push_bits(4'b0001, 16'h1, 1); push_bits(4'b0010, 16'h0, 1);
    push_bits(4'b0100, 16'h1, 1); push_bits(4'b1000, 16'h0, 1);
    push_bits(4'b0001, 16'h1, 1);
    Req = 4'b1111;
    run_burst(4'b0001, 1, -1, 4'b0000, 1'b0);
    run_burst(4'b0010, 1, -1, 4'b0000, 1'b1);
    run_burst(4'b0100, 1, -1, 4'b0000, 1'b1);
    run_burst(4'b1000, 1, -1, 4'b0000, 1'b1);
    run_burst(4'b0001, 1, 1, 4'b0000, 1'b1);

    // Serve requester 2 (pointer -> 3), then 0101 wraps to requester 0, then 0011 picks 1.
    set_len(2, 4'd1); pat[2] = 16'b10;
    set_len(0, 4'd2); pat[0] = 16'b011;
    push_bits(4'b0100, 16'b10, 2);
    push_bits(4'b0001, 16'b011, 3);
    Req = 4'b0100;
    run_burst(4'b0100, 2, 1, 4'b0101, 1'b0);
    run_burst(4'b0001, 3, 1, 4'b0000, 1'b0);
    set_len(1, 4'd0); pat[1] = 16'h0001;
    push_bits(4'b0010, 16'h1, 1);
    Req = 4'b0011;
    run_burst(4'b0010, 1, 1, 4'b0000, 1'b0);

    // Maximum length burst; Req dropped after 5 bits.
    set_len(1, 4'd15); pat[1] = 16'hC3A5;
    push_bits(4'b0010, 16'hC3A5, 16);
    Req = 4'b0010;
    run_burst(4'b0010, 16, 5, 4'b0000, 1'b0);

    // Reset during STREAM bit 2 of a 10-bit burst on requester 3.
    set_len(3, 4'd9); pat[3] = 16'h02AB;
    Req = 4'b1000;
    t = 0;
    while (!Busy && t < 40) begin
      @(negedge Clock);
      t++;
    end
    chk("abort_start", 32'(Busy), 32'd1);
    repeat (3) @(negedge Clock);
    chk("abort_pre_grant", 32'(Grant), 32'h8);
    chk("abort_pre_strobe", 32'(BitStrobe), 32'd1);
    Reset = 1'b1; Req = '0;
    #1;
    chk("abort_grant", 32'(Grant), 32'd0);
    chk("abort_engrst", 32'(EngRst), 32'd1);
    chk("abort_respvalid", 32'(RespValid), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    chk("abort_busy", 32'(Busy), 32'd0);
    repeat (2) begin
      @(negedge Clock);
      chk("abort_hold_rv", 32'(RespValid), 32'd0);
      chk("abort_hold_done", 32'(Done), 32'd0);
      chk("abort_hold_grant", 32'(Grant), 32'd0);
    end
    Reset = 1'b0;
    // Pointer is back at 0, so 1010 is won by requester 1, not 3.
    set_len(1, 4'd0);
    push_bits(4'b0010, 16'hC3A5, 1);
    Req = 4'b1010;
    run_burst(4'b0010, 1, 1, 4'b0000, 1'b0);
    chk("queue_empty", 32'(q.size()), 32'd0);

    // Latency sweep: LAT=1 and LAT=3, 2-bit burst 0,1 from requester 0.
    blen_s = 16'h0001; req_s = 4'b0001;
    t = 0;
    while (!b1 && t < 40) begin
      @(negedge Clock);
      t++;
    end
    chk("sweep_start", 32'(b1 && b3), 32'd1);
    for (int c = 0; c <= 7; c++) begin
      chk("l1_strobe", 32'(st1), 32'(c == 1 || c == 2));
      chk("l1_respvalid", 32'(rv1), 32'(c == 3 || c == 4));
      chk("l1_respbit", 32'(rb1), 32'(c == 4));
      chk("l1_done", 32'(d1), 32'(c == 4));
      chk("l1_busy", 32'(b1), 32'(c <= 4));
      chk("l3_strobe", 32'(st3), 32'(c == 1 || c == 2));
      chk("l3_respvalid", 32'(rv3), 32'(c == 5 || c == 6));
      chk("l3_respbit", 32'(rb3), 32'(c == 6));
      chk("l3_done", 32'(d3), 32'(c == 6));
      chk("l3_busy", 32'(b3), 32'(c <= 6));
      if (c == 1) req_s = '0;
      @(negedge Clock);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
